led_fade: RTL and testbench

- Brightness sequencer that sits directly upstream of the 8-bit PWM stage and drives its `bright` input.
- Accepts fade commands over a valid/ready handshake. Each command carries a target level and a step interval.
- Walks an internal 8-bit level toward the target by one LSB per interval.
- Presents the level, optionally gamma-squared, as a registered 8-bit brightness word.

---
 rtl/led_fade_if.sv | 24 ++
 rtl/led_fade.sv | 112 +++++++++++
 tb/tb_led_fade.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_fade_if.sv
// Fade-command handshake between a command source and the led_fade sequencer.
// The command fields are only meaningful while cmd_valid is high.
interface led_fade_if #(
  parameter int DIV_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_level;
  logic [DIV_W-1:0] cmd_div;

  modport master (
    output cmd_valid,
    output cmd_level,
    output cmd_div,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_level,
    input  cmd_div,
    output cmd_ready
  );
endinterface

// File: rtl/led_fade.sv
// Brightness sequencer feeding the 8-bit PWM stage: ramps an internal level toward a
// commanded target one LSB per interval and presents it (optionally gamma-squared) as bright.
module led_fade #(
  parameter int GAMMA = 0,
  parameter int DIV_W = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  led_fade_if.slave  cmd,
  output logic [7:0] bright,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [1:0]       state_q,  state_d;
  logic [7:0]       level_q,  level_d;
  logic [7:0]       target_q, target_d;
  logic [DIV_W-1:0] div_q,    div_d;
  logic [DIV_W-1:0] presc_q,  presc_d;
  logic [7:0]       bright_q, bright_d;
  logic             done_q,   done_d;

  logic             stepHit;
  logic [7:0]       levelStep;
  logic [15:0]      levelSq;

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign bright        = bright_q;

  assign stepHit   = (presc_q == (div_q - DIV_ONE));
  assign levelStep = (state_q == UP) ? (level_q + 8'd1) : (level_q - 8'd1);
  assign levelSq   = {8'd0, level_q} * {8'd0, level_q};

  // Stepping can never wrap: the ramp stops as soon as the stepped level meets the target,
  // and the target always lies on the far side of the level in the ramp direction.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    div_d    = div_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          target_d = cmd.cmd_level;
          div_d    = cmd.cmd_div;
          presc_d  = '0;
          if (cmd.cmd_div == '0) begin
            level_d = cmd.cmd_level;
            done_d  = 1'b1;
          end else if (cmd.cmd_level == level_q) begin
            done_d = 1'b1;
          end else if (cmd.cmd_level > level_q) begin
            state_d = UP;
          end else begin
            state_d = DOWN;
          end
        end
      end
      UP, DOWN: begin
        presc_d = presc_q + DIV_ONE;
        if (stepHit) begin
          presc_d = '0;
          level_d = levelStep;
          if (levelStep == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Squared mapping keeps 0->0, 1->1 and 255->255 thanks to the +255 rounding bias.
  always_comb begin
    bright_d = level_q;
    if (GAMMA != 0) begin
      bright_d = 8'((levelSq + 16'd255) >> 8);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      level_q  <= '0;
      target_q <= '0;
      div_q    <= '0;
      presc_q  <= '0;
      bright_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      div_q    <= div_d;
      presc_q  <= presc_d;
      bright_q <= bright_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_led_fade.sv
// Self-checking bench: a linear and a gamma instance receive identical commands and are
// compared every cycle against an arithmetic model of the fade timeline.
module tb_led_fade;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmdValid;
  logic [7:0]  cmdLevel;
  logic [15:0] cmdDiv;

  logic [7:0]  bright0, bright1;
  logic        busy0, busy1, done0, done1;

  int total = 0;
  int bad = 0;
  int modelLevel = 0;

  led_fade_if #(.DIV_W(16)) if0 ();
  led_fade_if #(.DIV_W(16)) if1 ();

  assign if0.cmd_valid = cmdValid;
  assign if0.cmd_level = cmdLevel;
  assign if0.cmd_div   = cmdDiv;
  assign if1.cmd_valid = cmdValid;
  assign if1.cmd_level = cmdLevel;
  assign if1.cmd_div   = cmdDiv;

  led_fade #(.GAMMA(0), .DIV_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .cmd(if0.slave),
    .bright(bright0), .busy(busy0), .done(done0)
  );

  led_fade #(.GAMMA(1), .DIV_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd(if1.slave),
    .bright(bright1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // Level seen after the t-th edge following the accept edge (t=-1 means before accept).
  function automatic int levelAt(int s, int g, int d, int t);
    int n, k;
    if (t < 0) return s;
    if (d == 0) return g;
    n = (g > s) ? g - s : s - g;
    k = t / d;
    if (k > n) k = n;
    return (g > s) ? s + k : s - k;
  endfunction

  function automatic int spanOf(int s, int g, int d);
    if (d == 0 || s == g) return 0;
    return ((g > s) ? g - s : s - g) * d;
  endfunction

  function automatic int gammaOf(int x);
    return (x * x + 255) / 256;
  endfunction

  task automatic test_reset();
    reset_n  = 1'b0;
    cmdValid = 1'b1;
    cmdLevel = 8'd77;
    cmdDiv   = 16'd0;
    repeat (2) @(negedge clk);
    total++;
    if ({bright0, bright1} !== 16'd0) begin
      bad++; $display("FAIL reset_bright got=%0d/%0d exp=0/0", bright0, bright1);
    end
    total++;
    if ({busy0, busy1, if0.cmd_ready, if1.cmd_ready, done0, done1} !== 6'b001100) begin
      bad++; $display("FAIL reset_flags got busy=%b ready=%b done=%b exp busy=0 ready=1 done=0", busy0, if0.cmd_ready, done0);
    end
    reset_n  = 1'b1;
    cmdValid = 1'b0;
    @(negedge clk);
    total++;
    if ({done0, done1, busy0, bright0} !== 11'd0) begin
      bad++; $display("FAIL reset_no_accept got done=%b busy=%b bright=%0d exp 0/0/0", done0, busy0, bright0);
    end
  endtask

  task automatic test_fade(input int lvl, input int div, input string name);
    int s, span, waitN, e0, e1;
    bit expBusy, expDone;
    s = modelLevel;
    span = spanOf(s, lvl, div);
    cmdLevel = 8'(lvl);
    cmdDiv   = 16'(div);
    cmdValid = 1'b1;
    waitN = 0;
    while (if0.cmd_ready !== 1'b1 && waitN < 50) begin
      @(negedge clk);
      waitN++;
    end
    total++;
    if (waitN >= 50) begin
      bad++; $display("FAIL %s accept_timeout got ready=%b exp=1", name, if0.cmd_ready);
      cmdValid = 1'b0;
      return;
    end
    @(negedge clk);
    cmdValid = 1'b0;
    for (int t = 0; t <= span + 1; t++) begin
      e0 = levelAt(s, lvl, div, t - 1);
      e1 = gammaOf(e0);
      expBusy = (t < span);
      expDone = (t == span);
      total++;
      if ({busy0, busy1, if0.cmd_ready, if1.cmd_ready} !== {expBusy, expBusy, ~expBusy, ~expBusy}) begin
        bad++; $display("FAIL %s busy t=%0d got busy=%b ready=%b exp busy=%b", name, t, busy0, if0.cmd_ready, expBusy);
      end
      total++;
      if ({done0, done1} !== {expDone, expDone}) begin
        bad++; $display("FAIL %s done t=%0d got=%b/%b exp=%b", name, t, done0, done1, expDone);
      end
      total++;
      if (bright0 !== 8'(e0)) begin
        bad++; $display("FAIL %s bright_lin t=%0d got=%0d exp=%0d", name, t, bright0, e0);
      end
      total++;
      if (bright1 !== 8'(e1)) begin
        bad++; $display("FAIL %s bright_gamma t=%0d got=%0d exp=%0d", name, t, bright1, e1);
      end
      if (t <= span) @(negedge clk);
    end
    modelLevel = lvl;
  endtask

  task automatic test_back_to_back();
    int s, e0;
    s = modelLevel;
    cmdLevel = 8'd1;
    cmdDiv   = 16'd1;
    cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    for (int t = 0; t <= 3; t++) begin
      e0 = levelAt(s, 1, 1, t - 1);
      total++;
      if ({busy0, done0, bright0} !== {(t < 3), (t == 3), 8'(e0)}) begin
        bad++; $display("FAIL b2b_ramp t=%0d got busy=%b done=%b bright=%0d exp busy=%b done=%b bright=%0d",
                        t, busy0, done0, bright0, (t < 3), (t == 3), e0);
      end
      if (t < 3) @(negedge clk);
    end
    total++;
    if (if0.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready_in_done got=%b exp=1", if0.cmd_ready);
    end
    cmdLevel = 8'd4;
    cmdDiv   = 16'd0;
    cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    total++;
    if ({done0, done1, busy0, bright0} !== {1'b1, 1'b1, 1'b0, 8'd1}) begin
      bad++; $display("FAIL b2b_accept got done=%b busy=%b bright=%0d exp done=1 busy=0 bright=1", done0, busy0, bright0);
    end
    @(negedge clk);
    total++;
    if ({done0, bright0, bright1} !== {1'b0, 8'd4, 8'(gammaOf(4))}) begin
      bad++; $display("FAIL b2b_settle got done=%b bright=%0d/%0d exp done=0 bright=4/%0d", done0, bright0, bright1, gammaOf(4));
    end
    modelLevel = 4;
  endtask

  task automatic test_midfade();
    int s, e0;
    s = modelLevel;
    cmdLevel = 8'd255;
    cmdDiv   = 16'd2;
    cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    for (int t = 0; t <= 200; t++) begin
      e0 = levelAt(s, 255, 2, t - 1);
      total++;
      if ({busy0, done0, done1, bright0, bright1} !== {3'b100, 8'(e0), 8'(gammaOf(e0))}) begin
        bad++; $display("FAIL mid_ramp t=%0d got busy=%b done=%b bright=%0d/%0d exp busy=1 done=0 bright=%0d/%0d",
                        t, busy0, done0, bright0, bright1, e0, gammaOf(e0));
      end
      if (t == 41) begin
        cmdLevel = 8'd17;
        cmdDiv   = 16'd0;
        cmdValid = 1'b1;
      end else if (t == 42) begin
        cmdValid = 1'b0;
      end
      if (t < 200) @(negedge clk);
    end
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy0, busy1, if0.cmd_ready, done0, done1, bright0, bright1} !== {5'b00100, 16'd0}) begin
      bad++; $display("FAIL mid_reset got busy=%b ready=%b done=%b bright=%0d/%0d exp 0/1/0/0/0",
                      busy0, if0.cmd_ready, done0, bright0, bright1);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({done0, done1, busy0, bright0} !== 11'd0) begin
      bad++; $display("FAIL mid_after_reset got done=%b busy=%b bright=%0d exp 0/0/0", done0, busy0, bright0);
    end
    modelLevel = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_fade(int'($urandom_range(0, 255)), int'($urandom_range(0, 6)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_fade(4, 3, "up_0_to_4");
    test_back_to_back();
    test_fade(4, 5, "equal_level");
    test_fade(200, 0, "jump_200");
    test_fade(255, 0, "jump_255");
    test_fade(1, 0, "jump_1");
    test_fade(0, 0, "jump_0");
    test_midfade();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
